// File: rtl/decode_stage_if.sv
// Shared decode types plus the fetch->decode and decode->rename handshake bundles.
// Each interface carries one valid/ready channel; the producer takes the master modport.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_BRANCH = 2'd1,
    FU_LSU    = 2'd2
  } fu_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    fu_e         fu_type;
    alu_op_e     alu_op;
    logic [2:0]  func3;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } dec_entry_t;

endpackage

interface fetch_if;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] pc_4_in;

  modport master (output valid_in, instr_in, pc_in, pc_4_in, input ready_in);
  modport slave  (input valid_in, instr_in, pc_in, pc_4_in, output ready_in);
endinterface

interface rename_if;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        writes_rd;
  logic [1:0]  fu_type;
  logic [3:0]  alu_op;
  logic [2:0]  func3;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jump;
  logic        illegal;

  modport master (output valid_out, pc_out, pc_4_out, rs1, rs2, rd, imm, uses_rs1, uses_rs2,
                         writes_rd, fu_type, alu_op, func3, is_load, is_store, is_branch,
                         is_jump, illegal,
                  input  ready_out);
  modport slave  (input  valid_out, pc_out, pc_4_out, rs1, rs2, rd, imm, uses_rs1, uses_rs2,
                         writes_rd, fu_type, alu_op, func3, is_load, is_store, is_branch,
                         is_jump, illegal,
                  output ready_out);
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decoder feeding a registered main/skid buffer.
// Outputs come only from the main register; ready_in depends only on skid occupancy.
module decode_stage
  import decode_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      mispredict,
  fetch_if.slave    fetch,
  rename_if.master  rename
);

  dec_entry_t dec;
  dec_entry_t main_q, skid_q;
  logic       main_valid, skid_valid;
  logic       take_in, drain;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic f7_b5,
                                          input logic is_reg_op);
    unique case (f3)
      3'd0:    alu_from_f3 = (is_reg_op && f7_b5) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_from_f3 = ALU_SLL;
      3'd2:    alu_from_f3 = ALU_SLT;
      3'd3:    alu_from_f3 = ALU_SLTU;
      3'd4:    alu_from_f3 = ALU_XOR;
      3'd5:    alu_from_f3 = f7_b5 ? ALU_SRA : ALU_SRL;
      3'd6:    alu_from_f3 = ALU_OR;
      default: alu_from_f3 = ALU_AND;
    endcase
  endfunction

  always_comb begin
    logic [31:0] i;
    i = fetch.instr_in;
    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    dec       = '0;
    dec.pc    = fetch.pc_in;
    dec.pc_4  = fetch.pc_4_in;
    dec.rs1   = i[19:15];
    dec.rs2   = i[24:20];
    dec.rd    = i[11:7];
    dec.func3 = i[14:12];
    unique case (i[6:0])
      OPC_OP: begin
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.alu_op    = alu_from_f3(i[14:12], i[30], 1'b1);
      end
      OPC_OP_IMM: begin
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.imm       = {{20{i[31]}}, i[31:20]};
        dec.alu_op    = alu_from_f3(i[14:12], i[30], 1'b0);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.writes_rd = 1'b1;
        dec.imm       = {i[31:12], 12'b0};
        dec.alu_op    = (i[6:0] == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
      end
      OPC_JAL: begin
        dec.fu_type   = FU_BRANCH;
        dec.is_jump   = 1'b1;
        dec.writes_rd = 1'b1;
        dec.imm       = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.fu_type   = FU_BRANCH;
        dec.is_jump   = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.imm       = {{20{i[31]}}, i[31:20]};
      end
      OPC_BRANCH: begin
        dec.fu_type   = FU_BRANCH;
        dec.is_branch = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.imm       = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      OPC_LOAD: begin
        dec.fu_type   = FU_LSU;
        dec.is_load   = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.imm       = {{20{i[31]}}, i[31:20]};
      end
      OPC_STORE: begin
        dec.fu_type   = FU_LSU;
        dec.is_store  = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.imm       = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      default: dec.illegal = 1'b1;
    endcase
    // x0 is never a real destination.
    if (dec.rd == 5'd0) dec.writes_rd = 1'b0;
  end

  assign take_in        = fetch.valid_in && fetch.ready_in;
  assign drain          = main_valid && rename.ready_out;
  assign fetch.ready_in = !skid_valid;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      // NOTE: data registers are cleared too, so outputs read as zero straight out of reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else if (mispredict) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= take_in;
        if (take_in) main_q <= dec;
      end
    end else if (take_in) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign rename.valid_out = main_valid;
  assign rename.pc_out    = main_q.pc;
  assign rename.pc_4_out  = main_q.pc_4;
  assign rename.rs1       = main_q.rs1;
  assign rename.rs2       = main_q.rs2;
  assign rename.rd        = main_q.rd;
  assign rename.imm       = main_q.imm;
  assign rename.uses_rs1  = main_q.uses_rs1;
  assign rename.uses_rs2  = main_q.uses_rs2;
  assign rename.writes_rd = main_q.writes_rd;
  assign rename.fu_type   = main_q.fu_type;
  assign rename.alu_op    = main_q.alu_op;
  assign rename.func3     = main_q.func3;
  assign rename.is_load   = main_q.is_load;
  assign rename.is_store  = main_q.is_store;
  assign rename.is_branch = main_q.is_branch;
  assign rename.is_jump   = main_q.is_jump;
  assign rename.illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instruction-level reference decoder plus a 2-deep in-order queue
// model, compared every cycle, alongside hand-computed expectations for directed vectors.
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset, mispredict;
  always #5 clk = ~clk;

  fetch_if  f();
  rename_if r();

  decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .mispredict (mispredict),
    .fetch      (f),
    .rename     (r)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [1:0]  fu_type;
    logic [3:0]  alu_op;
    logic [2:0]  func3;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } out_t;

  typedef enum {K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LOAD, K_STORE, K_BAD} kind_e;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_e(input string name, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t actual();
    out_t a;
    a.pc        = r.pc_out;
    a.pc_4      = r.pc_4_out;
    a.rs1       = r.rs1;
    a.rs2       = r.rs2;
    a.rd        = r.rd;
    a.imm       = r.imm;
    a.uses_rs1  = r.uses_rs1;
    a.uses_rs2  = r.uses_rs2;
    a.writes_rd = r.writes_rd;
    a.fu_type   = r.fu_type;
    a.alu_op    = r.alu_op;
    a.func3     = r.func3;
    a.is_load   = r.is_load;
    a.is_store  = r.is_store;
    a.is_branch = r.is_branch;
    a.is_jump   = r.is_jump;
    a.illegal   = r.illegal;
    return a;
  endfunction

  // Reference decoder: classify the opcode, then derive each field from the ISA rules.
  function automatic out_t model_decode(input logic [31:0] i, input logic [31:0] pc);
    out_t  o;
    kind_e k;
    int    v;
    int    a;
    int    alu_tab[8];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    o       = '0;
    o.pc    = pc;
    o.pc_4  = pc + 32'd4;
    o.rs1   = i[19:15];
    o.rs2   = i[24:20];
    o.rd    = i[11:7];
    o.func3 = i[14:12];
    case (i[6:0])
      7'h33:   k = K_OP;
      7'h13:   k = K_OPIMM;
      7'h37:   k = K_LUI;
      7'h17:   k = K_AUIPC;
      7'h6F:   k = K_JAL;
      7'h67:   k = K_JALR;
      7'h63:   k = K_BR;
      7'h03:   k = K_LOAD;
      7'h23:   k = K_STORE;
      default: k = K_BAD;
    endcase
    v = 0;
    case (k)
      K_OPIMM, K_LOAD, K_JALR: begin
        v = int'(i[31:20]);
        if (i[31]) v -= 4096;
      end
      K_STORE: begin
        v = int'({i[31:25], i[11:7]});
        if (i[31]) v -= 4096;
      end
      K_BR: begin
        v = 2 * int'({i[31], i[7], i[30:25], i[11:8]});
        if (i[31]) v -= 8192;
      end
      K_LUI, K_AUIPC: v = int'(i[31:12]) * 4096;
      K_JAL: begin
        v = 2 * int'({i[31], i[19:12], i[20], i[30:21]});
        if (i[31]) v -= (1 << 21);
      end
      default: v = 0;
    endcase
    o.imm = v;
    a = 0;
    if (k == K_OP || k == K_OPIMM) begin
      a = alu_tab[i[14:12]];
      if (i[30] && i[14:12] == 3'd5) a = 7;
      if (i[30] && k == K_OP && i[14:12] == 3'd0) a = 1;
    end else if (k == K_LUI) a = 10;
    else if (k == K_AUIPC) a = 11;
    o.alu_op    = 4'(a);
    o.uses_rs1  = k inside {K_OP, K_OPIMM, K_JALR, K_BR, K_LOAD, K_STORE};
    o.uses_rs2  = k inside {K_OP, K_BR, K_STORE};
    o.writes_rd = (k inside {K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD}) && (i[11:7] != 5'd0);
    o.fu_type   = (k inside {K_BR, K_JAL, K_JALR}) ? 2'd1 : (k inside {K_LOAD, K_STORE}) ? 2'd2 : 2'd0;
    o.is_load   = (k == K_LOAD);
    o.is_store  = (k == K_STORE);
    o.is_branch = (k == K_BR);
    o.is_jump   = (k == K_JAL || k == K_JALR);
    o.illegal   = (k == K_BAD);
    return o;
  endfunction

  // Stage behaves as an in-order queue of at most two entries; flush/reset empty it.
  out_t q[$];

  always @(posedge clk) begin
    logic acc;
    acc = f.valid_in && (q.size() < 2);
    if (reset || mispredict) q.delete();
    else begin
      if (q.size() > 0 && r.ready_out) void'(q.pop_front());
      if (acc) q.push_back(model_decode(f.instr_in, f.pc_in));
    end
  end

  always @(negedge clk) begin
    check("valid_out_vs_model", 32'(r.valid_out), 32'(q.size() > 0));
    check("ready_in_vs_model", 32'(f.ready_in), 32'(q.size() < 2));
    if (r.valid_out && q.size() > 0) check_e("entry_vs_model", actual(), q[0]);
  end

  task automatic present(input logic [31:0] i, input logic [31:0] pc);
    f.valid_in = 1'b1;
    f.instr_in = i;
    f.pc_in    = pc;
    f.pc_4_in  = pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] pc);
    f.valid_in = 1'b1;
    f.instr_in = i;
    f.pc_in    = pc;
    f.pc_4_in  = pc + 32'd4;
  endtask

  logic [31:0] extra_vec [8];

  initial begin
    out_t m;
    reset        = 1'b1;
    mispredict   = 1'b0;
    f.valid_in   = 1'b0;
    f.instr_in   = '0;
    f.pc_in      = '0;
    f.pc_4_in    = '0;
    r.ready_out  = 1'b1;

    // Pin the reference decoder against hand-decoded fields.
    m = model_decode(32'hFE208CE3, 32'h0);
    check("model_beq_imm", m.imm, 32'hFFFFFFF8);
    m = model_decode(32'h010000EF, 32'h0);
    check("model_jal_imm", m.imm, 32'h00000010);
    m = model_decode(32'hFE21AE23, 32'h0);
    check("model_sw_imm", m.imm, 32'hFFFFFFFC);
    m = model_decode(32'h40525193, 32'h0);
    check("model_srai_alu", 32'(m.alu_op), 32'd7);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_valid_out", 32'(r.valid_out), 32'd0);
    check("reset_ready_in", 32'(f.ready_in), 32'd1);
    check_e("reset_outputs_zero", actual(), '0);

    // Directed decodes, back to back with ready_out high.
    present(32'hFFF00293, 32'h100);
    check("addi_valid", 32'(r.valid_out), 32'd1);
    check("addi_rd", 32'(r.rd), 32'd5);
    check("addi_rs1", 32'(r.rs1), 32'd0);
    check("addi_imm", r.imm, 32'hFFFFFFFF);
    check("addi_alu", 32'(r.alu_op), 32'd0);
    check("addi_fu", 32'(r.fu_type), 32'd0);
    check("addi_wr", 32'(r.writes_rd), 32'd1);
    check("addi_urs2", 32'(r.uses_rs2), 32'd0);
    check("addi_pc4", r.pc_4_out, 32'h104);

    present(32'hFE208CE3, 32'h104);
    check("beq_rs1", 32'(r.rs1), 32'd1);
    check("beq_rs2", 32'(r.rs2), 32'd2);
    check("beq_imm", r.imm, 32'hFFFFFFF8);
    check("beq_fu", 32'(r.fu_type), 32'd1);
    check("beq_f3", 32'(r.func3), 32'd0);
    check("beq_isbr", 32'(r.is_branch), 32'd1);
    check("beq_wr", 32'(r.writes_rd), 32'd0);

    present(32'h40208033, 32'h108);
    check("sub_alu", 32'(r.alu_op), 32'd1);
    check("sub_wr_x0", 32'(r.writes_rd), 32'd0);

    present(32'h0000007F, 32'h10C);
    check("ill7f_illegal", 32'(r.illegal), 32'd1);
    check("ill7f_wr", 32'(r.writes_rd), 32'd0);
    check("ill7f_valid", 32'(r.valid_out), 32'd1);

    present(32'h00000000, 32'h110);
    check("ill0_illegal", 32'(r.illegal), 32'd1);
    check("ill0_wr", 32'(r.writes_rd), 32'd0);
    check("ill0_valid", 32'(r.valid_out), 32'd1);

    present(32'h40008093, 32'h114);
    check("addi_bit30_not_sub", 32'(r.alu_op), 32'd0);
    check("addi_bit30_imm", r.imm, 32'h00000400);

    present(32'h010000EF, 32'h118);
    check("jal_jump", 32'(r.is_jump), 32'd1);
    check("jal_urs1", 32'(r.uses_rs1), 32'd0);
    check("jal_wr", 32'(r.writes_rd), 32'd1);

    // Further formats checked against the reference decoder only.
    extra_vec = '{32'hFE21AE23, 32'h123453B7, 32'hFFFFF417, 32'h0080A303,
                  32'h00008067, 32'h40525193, 32'h402081B3, 32'h0020A193};
    for (int k = 0; k < 8; k++) present(extra_vec[k], 32'h120 + 32'(4 * k));
    f.valid_in = 1'b0;
    @(negedge clk);

    // Backpressure: A held in main, B in skid, then drained in order.
    r.ready_out = 1'b0;
    present(32'h00100093, 32'h200);
    present(32'h00200113, 32'h204);
    check("bp_ready_low", 32'(f.ready_in), 32'd0);
    check("bp_hold_a", r.pc_out, 32'h200);
    offer(32'h00300193, 32'h208);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall_a", r.pc_out, 32'h200);
      check("bp_stall_ready", 32'(f.ready_in), 32'd0);
    end
    r.ready_out = 1'b1;
    @(negedge clk);
    check("bp_out_b", r.pc_out, 32'h204);
    check("bp_ready_back", 32'(f.ready_in), 32'd1);
    @(negedge clk);
    check("bp_out_c", r.pc_out, 32'h208);
    offer(32'h00400213, 32'h20C);
    @(negedge clk);
    check("bp_out_d", r.pc_out, 32'h20C);
    f.valid_in = 1'b0;
    @(negedge clk);
    check("bp_empty", 32'(r.valid_out), 32'd0);

    // Flush with both buffers full and a third entry offered.
    r.ready_out = 1'b0;
    present(32'h00500293, 32'h300);
    present(32'h00600313, 32'h304);
    offer(32'h00700393, 32'h308);
    mispredict = 1'b1;
    @(negedge clk);
    mispredict  = 1'b0;
    f.valid_in  = 1'b0;
    check("flush_valid_out", 32'(r.valid_out), 32'd0);
    check("flush_ready_in", 32'(f.ready_in), 32'd1);
    r.ready_out = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_stays_empty", 32'(r.valid_out), 32'd0);
    end

    // Reset mid-stream, then resume.
    present(32'h00800413, 32'h400);
    present(32'h00900493, 32'h404);
    offer(32'h00A00513, 32'h408);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    f.valid_in = 1'b0;
    check("midrst_valid_out", 32'(r.valid_out), 32'd0);
    check("midrst_ready_in", 32'(f.ready_in), 32'd1);
    check_e("midrst_outputs_zero", actual(), '0);
    present(32'hFFF00293, 32'h500);
    check("resume_valid", 32'(r.valid_out), 32'd1);
    check("resume_rd", 32'(r.rd), 32'd5);
    check("resume_pc", r.pc_out, 32'h500);
    f.valid_in = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the out-of-order RV32I front end. It sits directly downstream of fetch and upstream of rename. It accepts one `{pc, instr, pc+4}` per cycle over a valid/ready handshake and decodes the instruction into register specifiers, a sign-extended immediate, functional-unit class and ALU op. The result is presented to rename from a registered 2-entry skid buffer, and the whole stage is flushed on `mispredict`.

## Interface
- No parameters.
- `clk  in  1`  clock; all state updates on rising edge.
- `reset  in  1`  synchronous, active-high.
- `mispredict  in  1`  flush; drops all buffered and incoming entries.
- `valid_in  in  1`  fetch entry valid.
- `ready_in  out  1`  stage can accept an entry this cycle.
- `instr_in  in  32`  raw instruction.
- `pc_in  in  32`  instruction PC.
- `pc_4_in  in  32`  PC+4 from fetch.
- `valid_out  out  1`  decoded entry valid.
- `ready_out  in  1`  rename accepts entry.
- `pc_out, pc_4_out  out  32`  passed through.
- `rs1, rs2, rd  out  5`  register specifiers.
- `imm  out  32`  sign-extended immediate.
- `uses_rs1, uses_rs2, writes_rd  out  1`  operand/destination usage.
- `fu_type  out  2`  0=ALU, 1=BRANCH, 2=LSU.
- `alu_op  out  4`  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (pass imm), 11 AUIPC (pc+imm).
- `func3  out  3`  raw funct3 for branch compare and load/store size.
- `is_load, is_store, is_branch, is_jump, illegal  out  1`  class flags.

## Operation
- Combinational decoder on `instr_in` feeds a 2-entry buffer of main and skid registers. Outputs come only from main; no combinational path runs from inputs to outputs.
- Immediate generation by format:
  - I: `{{20{i[31]}},i[31:20]}`.
  - S: `{{20{i[31]}},i[31:25],i[11:7]}`.
  - B: `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`.
  - U: `{i[31:12],12'b0}`.
  - J: `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`.
  - R-type: imm=0.
- Opcode classes:
  - OP / OP-IMM → ALU. Op comes from funct3, with funct7[5] selecting SUB/SRA. OP-IMM uses funct7[5] only for shifts; ADDI never decodes as SUB.
  - LUI / AUIPC → ALU.
  - BRANCH → BRANCH.
  - JAL / JALR → BRANCH with is_jump=1, writes_rd.
  - LOAD / STORE → LSU.
- `uses_rs1=0` for LUI/AUIPC/JAL. `uses_rs2=1` only for OP/BRANCH/STORE.
- `writes_rd = 0` whenever rd==0, or for BRANCH/STORE.
- Unsupported opcode (including all-zero word): illegal=1, writes_rd=0, uses_rs1=uses_rs2=0, fu_type=ALU. The entry still flows downstream.

## Timing
- Latency: an entry accepted at edge N appears on `valid_out` after edge N (1 cycle).
- Transfer in occurs when `valid_in && ready_in`. Transfer out occurs when `valid_out && ready_out`.
- `ready_in = !skid_valid`, driven from a register. It is not combinational on `ready_out`.
- Buffer rules:
  - Main empty, or main draining this cycle: the incoming entry goes to main.
  - Main full and stalled: the incoming entry goes to skid.
  - When main drains and skid is valid: skid moves to main. A new entry cannot arrive that cycle because `ready_in=0`.
- Order is strictly preserved. At most 2 entries are in flight.
- `mispredict` clears main and skid valid bits at the edge. An entry offered in the same cycle is dropped. The cycle after, `valid_out=0` and `ready_in=1`.
- `mispredict` takes priority over every transfer. `reset` takes priority over `mispredict`.
- Reset values: `valid_out=0`, `ready_in=1`, all data outputs 0 (main and skid data registers cleared).
- Throughput: 1 entry/cycle with `ready_out` held high.

## Test plan
- `0xFFF00293` (addi x5,x0,-1), pc=0x100 → next cycle: valid_out=1, rd=5, rs1=0, imm=0xFFFFFFFF, alu_op=0, fu_type=0, writes_rd=1, uses_rs2=0, pc_4_out=0x104.
- `0xFE208CE3` (beq x1,x2,-8) → rs1=1, rs2=2, imm=0xFFFFFFF8, fu_type=1, func3=0, is_branch=1, writes_rd=0.
- `0x40208033` (sub x0,x1,x2) → alu_op=1, writes_rd=0 (rd=x0). `0x0000007F` and `0x00000000` → illegal=1, writes_rd=0, valid_out=1.
- Backpressure: stream 4 entries A–D with ready_out=0 from cycle 1.
  - A is held on the outputs, B sits in skid, and ready_in drops to 0.
  - Raise ready_out: A, B, C, D exit in order on consecutive cycles, with no drops or duplicates.
- Mispredict with both buffers full and valid_in=1 → next cycle valid_out=0, ready_in=1. None of the three entries ever appears.
- Reset asserted mid-stream for 1 cycle → valid_out=0, ready_in=1, all outputs 0. Normal decode resumes on the following accepted entry.
